// File: rtl/uart_tx_scheduler_pkg.sv
// Shared UART definitions: FSM state encoding and the line levels used by the
// UART transmit/receive blocks.
package uart_tx_scheduler_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Idle (mark) level of the serial line; the start bit is its complement.
  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// FIFO read port between the TX scheduler (master) and the TX FIFO (slave).
interface uart_tx_scheduler_if
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  logic                  fifo_empty;
  logic                  fifo_read_enable;
  logic                  fifo_read_ack;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (
    input  fifo_empty,
    output fifo_read_enable,
    input  fifo_read_ack,
    input  fifo_data
  );

  modport slave (
    output fifo_empty,
    input  fifo_read_enable,
    output fifo_read_ack,
    output fifo_data
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud-rate divider shared by the UART TX and RX paths. The divisor is
// captured on load and held, so a bit period cannot change under a frame.
module uart_baud_tick
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_hold;
  logic [DIV_WIDTH-1:0] count;

  // Count down from the held divisor to zero, reloading on zero; load restarts the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_hold <= '0;
      count    <= '0;
    end else if (load) begin
      div_hold <= divisor;
      count    <= divisor;
    end else if (count == '0) begin
      count <= div_hold;
    end else begin
      count <= count - DIV_WIDTH'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: pops characters from the TX FIFO and serialises
// them as start / LSB-first data / stop frames on a registered tx line.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [DIV_WIDTH-1:0]    baud_div,
  uart_tx_scheduler_if.master     fifo,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  state_t                state;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shifter;
  logic                  load;
  logic                  tick;
  logic                  pop_ok;

  // The divisor is sampled exactly when a popped character is accepted.
  assign load   = (state == ST_FETCH) && fifo.fifo_read_ack;
  assign pop_ok = enable && !fifo.fifo_empty;
  assign busy   = (state != ST_IDLE);

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (resetn),
    .load    (load),
    .divisor (baud_div),
    .tick    (tick)
  );

  // Frame sequencer: one pop per frame, then start, data and stop bits.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state                 <= ST_IDLE;
      tx                    <= TX_IDLE_LEVEL;
      tx_done               <= 1'b0;
      fifo.fifo_read_enable <= 1'b0;
      bit_cnt               <= '0;
      shifter               <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= TX_IDLE_LEVEL;
          if (fifo.fifo_read_enable) begin
            fifo.fifo_read_enable <= 1'b0;
            state                 <= ST_FETCH;
          end else if (pop_ok) begin
            fifo.fifo_read_enable <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (fifo.fifo_read_ack) begin
            shifter <= fifo.fifo_data;
            tx      <= TX_START_LEVEL;
            bit_cnt <= '0;
            state   <= ST_START;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_START: begin
          if (tick) begin
            tx      <= shifter[0];
            shifter <= shifter >> 1;
            bit_cnt <= BIT_W'(1);
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == BIT_W'(DATA_WIDTH)) begin
              tx      <= TX_IDLE_LEVEL;
              bit_cnt <= '0;
              state   <= ST_STOP;
            end else begin
              tx      <= shifter[0];
              shifter <= shifter >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              state                 <= ST_IDLE;
              tx_done               <= 1'b1;
              bit_cnt               <= '0;
              fifo.fifo_read_enable <= pop_ok;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: begin
          state                 <= ST_IDLE;
          tx                    <= TX_IDLE_LEVEL;
          fifo.fifo_read_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: dut0 uses one stop bit, dut1 two.
// Each DUT is fed by a small FIFO model that acks one cycle after a pop.
module tb_uart_tx_scheduler;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [9:0]  bits;
    int          done_at;
    int          busy_cycles;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic [1:0]  enable_v;
  logic [15:0] div_v [2];
  logic [1:0]  tx_v;
  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [1:0]  rden_v;

  logic [7:0]  mem [2][16];
  logic [3:0]  wr_ptr [2] = '{4'd0, 4'd0};
  logic [3:0]  rd_ptr [2] = '{4'd0, 4'd0};
  int          pops [2] = '{0, 0};
  int          flush_req [2] = '{0, 0};
  int          flush_seen [2] = '{0, 0};
  logic [1:0]  ack_r = 2'b00;
  logic [7:0]  data_r [2] = '{8'h00, 8'h00};

  logic        cap_tx   [128];
  logic        cap_busy [128];
  logic        cap_done [128];
  logic        cap_rden [128];

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [5];

  uart_tx_scheduler_if #(.DATA_WIDTH(8)) fif0 ();
  uart_tx_scheduler_if #(.DATA_WIDTH(8)) fif1 ();

  assign fif0.fifo_empty    = (wr_ptr[0] == rd_ptr[0]);
  assign fif1.fifo_empty    = (wr_ptr[1] == rd_ptr[1]);
  assign fif0.fifo_read_ack = ack_r[0];
  assign fif1.fifo_read_ack = ack_r[1];
  assign fif0.fifo_data     = data_r[0];
  assign fif1.fifo_data     = data_r[1];
  assign rden_v             = {fif1.fifo_read_enable, fif0.fifo_read_enable};

  uart_tx_scheduler #(.DATA_WIDTH(8), .STOP_BITS(1), .DIV_WIDTH(16)) dut0 (
    .clk(clk), .resetn(resetn), .enable(enable_v[0]), .baud_div(div_v[0]),
    .fifo(fif0.master), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0])
  );

  uart_tx_scheduler #(.DATA_WIDTH(8), .STOP_BITS(2), .DIV_WIDTH(16)) dut1 (
    .clk(clk), .resetn(resetn), .enable(enable_v[1]), .baud_div(div_v[1]),
    .fifo(fif1.master), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: a pop request is acknowledged with data one cycle later; a flush wins over a pop.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (flush_req[k] != flush_seen[k]) begin
        flush_seen[k] <= flush_req[k];
        rd_ptr[k]     <= wr_ptr[k];
        ack_r[k]      <= 1'b0;
      end else if (rden_v[k] && (rd_ptr[k] != wr_ptr[k])) begin
        ack_r[k]  <= 1'b1;
        data_r[k] <= mem[k][rd_ptr[k]];
        rd_ptr[k] <= rd_ptr[k] + 4'd1;
        pops[k]   <= pops[k] + 1;
      end else begin
        ack_r[k] <= 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    mem[k][wr_ptr[k]] = d;
    wr_ptr[k] = wr_ptr[k] + 4'd1;
  endtask

  task automatic applyStimulus(input int k, input vec_t v);
    div_v[k] = v.div;
    push(k, v.data);
    enable_v[k] = 1'b1;
  endtask

  task automatic wait_pop(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rden_v[k]) begin
        ok = 1'b1;
        return;
      end
    end
    checkOutput("pop_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture(input int k, input int n, input int drop_at, input int rst_at,
                         input int div_at, input logic [15:0] new_div);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      cap_tx[i]   = tx_v[k];
      cap_busy[i] = busy_v[k];
      cap_done[i] = done_v[k];
      cap_rden[i] = rden_v[k];
      if (i == drop_at) enable_v[k] = 1'b0;
      if (i == rst_at) resetn = 1'b1;
      if (i == rst_at + 1) resetn = 1'b0;
      if (i == div_at) div_v[k] = new_div;
    end
  endtask

  function automatic logic sample(input int which, input int i);
    case (which)
      0:       return cap_tx[i];
      1:       return cap_busy[i];
      2:       return cap_done[i];
      default: return cap_rden[i];
    endcase
  endfunction

  function automatic logic [31:0] pack(input int which, input int first, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = sample(which, first + i);
    return r;
  endfunction

  function automatic int count(input int which, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (sample(which, i)) c++;
    return c;
  endfunction

  function automatic int first_index(input int which, input int n);
    for (int i = 0; i < n; i++) if (sample(which, i)) return i;
    return -1;
  endfunction

  // Each frame bit must hold one level for its whole period; an unstable bit reads as 2.
  task automatic check_frame(input string name, input int base, input int bitlen,
                             input int stoplen, input logic [9:0] exp_bits);
    logic v;
    bit   stable;
    int   len;
    int   st;
    checkOutput({name, " idle_before"}, 32'(cap_tx[base-1]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      len    = (i == 9) ? stoplen : bitlen;
      st     = base + i * bitlen;
      v      = cap_tx[st];
      stable = 1'b1;
      for (int c = 1; c < len; c++) if (cap_tx[st + c] !== v) stable = 1'b0;
      checkOutput($sformatf("%s bit%0d", name, i), stable ? 32'(v) : 32'd2, 32'(exp_bits[i]));
    end
  endtask

  initial begin
    bit ok;
    int p;

    vecs[0] = '{8'hA5, 16'd3, 10'h34A, 42, 41};
    vecs[1] = '{8'h00, 16'd0, 10'h200, 12, 11};
    vecs[2] = '{8'hFF, 16'd0, 10'h3FE, 12, 11};
    vecs[3] = '{8'h3C, 16'd1, 10'h278, 22, 21};
    vecs[4] = '{8'h5A, 16'd2, 10'h2B4, 32, 31};

    resetn   = 1'b1;
    enable_v = 2'b00;
    div_v[0] = 16'd0;
    div_v[1] = 16'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset tx", 32'(tx_v[0]), 32'd1);
    checkOutput("reset busy", 32'(busy_v[0]), 32'd0);
    checkOutput("reset tx_done", 32'(done_v[0]), 32'd0);
    checkOutput("reset read_enable", 32'(rden_v[0]), 32'd0);
    checkOutput("reset tx dut1", 32'(tx_v[1]), 32'd1);
    resetn = 1'b0;
    @(negedge clk);

    $display("[TB] single-frame vectors");
    for (int v = 0; v < 5; v++) begin
      p = pops[0];
      applyStimulus(0, vecs[v]);
      wait_pop(0, ok);
      if (ok) begin
        capture(0, vecs[v].done_at + 3, -1, -1, -1, 16'd0);
        check_frame($sformatf("vec%0d", v), 2, int'(vecs[v].div) + 1, int'(vecs[v].div) + 1, vecs[v].bits);
        checkOutput($sformatf("vec%0d done_at", v), first_index(2, vecs[v].done_at + 3), vecs[v].done_at);
        checkOutput($sformatf("vec%0d done_count", v), count(2, vecs[v].done_at + 3), 1);
        checkOutput($sformatf("vec%0d busy_cycles", v), count(1, vecs[v].done_at + 3), vecs[v].busy_cycles);
        checkOutput($sformatf("vec%0d read_enable_count", v), count(3, vecs[v].done_at + 3), 1);
        checkOutput($sformatf("vec%0d pops", v), pops[0] - p, 1);
      end
    end

    $display("[TB] back-to-back frames");
    p = pops[0];
    div_v[0] = 16'd0;
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_pop(0, ok);
    if (ok) begin
      capture(0, 30, -1, -1, -1, 16'd0);
      checkOutput("b2b tx", pack(0, 0, 30), 32'h3FFFB803);
      checkOutput("b2b busy", pack(1, 0, 30), 32'h00FFEFFE);
      checkOutput("b2b tx_done", pack(2, 0, 30), 32'h01001000);
      checkOutput("b2b read_enable", pack(3, 0, 30), 32'h00001001);
      checkOutput("b2b pops", pops[0] - p, 2);
      checkOutput("b2b fifo_empty", 32'(fif0.fifo_empty), 32'd1);
    end

    $display("[TB] flush race");
    p = pops[0];
    push(0, 8'h77);
    wait_pop(0, ok);
    if (ok) begin
      flush_req[0] = flush_req[0] + 1;
      capture(0, 12, -1, -1, -1, 16'd0);
      checkOutput("flush tx", pack(0, 0, 12), 32'hFFF);
      checkOutput("flush busy", pack(1, 0, 12), 32'h002);
      checkOutput("flush tx_done", pack(2, 0, 12), 32'h000);
      checkOutput("flush read_enable", pack(3, 0, 12), 32'h001);
      checkOutput("flush pops", pops[0] - p, 0);
    end

    $display("[TB] enable drop");
    div_v[0] = 16'd1;
    push(0, 8'h3C);
    push(0, 8'h11);
    wait_pop(0, ok);
    if (ok) begin
      capture(0, 40, 10, -1, -1, 16'd0);
      check_frame("drop", 2, 2, 2, 10'h278);
      checkOutput("drop done_at", first_index(2, 40), 22);
      checkOutput("drop read_enable", pack(3, 0, 32), 32'h1);
      checkOutput("drop read_enable_count", count(3, 40), 1);
      checkOutput("drop tx_idle_after", pack(0, 22, 18), 32'h3FFFF);
    end
    enable_v[0] = 1'b1;
    wait_pop(0, ok);
    checkOutput("reenable pop", 32'(ok), 32'd1);
    if (ok) begin
      capture(0, 25, -1, -1, -1, 16'd0);
      check_frame("reenable", 2, 2, 2, 10'h222);
      checkOutput("reenable done_at", first_index(2, 25), 22);
    end

    $display("[TB] reset mid-frame");
    p = pops[0];
    push(0, 8'hC3);
    push(0, 8'h5A);
    wait_pop(0, ok);
    if (ok) begin
      capture(0, 14, -1, 12, -1, 16'd0);
      checkOutput("rst early bits", pack(0, 2, 10), 32'h03C);
      checkOutput("rst tx before", 32'(cap_tx[12]), 32'd0);
      checkOutput("rst busy before", 32'(cap_busy[12]), 32'd1);
      checkOutput("rst tx after", 32'(cap_tx[13]), 32'd1);
      checkOutput("rst busy after", 32'(cap_busy[13]), 32'd0);
      checkOutput("rst tx_done after", 32'(cap_done[13]), 32'd0);
      checkOutput("rst read_enable after", 32'(cap_rden[13]), 32'd0);
    end
    wait_pop(0, ok);
    if (ok) begin
      capture(0, 25, -1, -1, -1, 16'd0);
      check_frame("post_rst", 2, 2, 2, 10'h2B4);
      checkOutput("post_rst done_at", first_index(2, 25), 22);
      checkOutput("post_rst pops", pops[0] - p, 2);
    end

    $display("[TB] divisor change, two stop bits");
    div_v[1] = 16'd1;
    push(1, 8'h81);
    push(1, 8'h42);
    enable_v[1] = 1'b1;
    wait_pop(1, ok);
    if (ok) begin
      capture(1, 120, -1, -1, 6, 16'd7);
      check_frame("div f1", 2, 2, 4, 10'h302);
      check_frame("div f2", 26, 8, 16, 10'h284);
      checkOutput("div done first", first_index(2, 120), 24);
      checkOutput("div done second", 32'(cap_done[114]), 32'd1);
      checkOutput("div done_count", count(2, 120), 2);
      checkOutput("div second pop", 32'(cap_rden[24]), 32'd1);
      checkOutput("div read_enable_count", count(3, 120), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: character width in bits.
REQ-002 SHALL have parameter STOP_BITS, default 1: stop bits per frame (1 or 2).
REQ-003 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits new frames to start.
REQ-007 SHALL have port baud_div  input  DIV_WIDTH  each bit lasts baud_div+1 clk cycles.
REQ-008 SHALL have port fifo_empty  input  1  TX FIFO empty flag (combinational from the FIFO).
REQ-009 SHALL have port fifo_read_enable  output  1  registered one-cycle pop request to the FIFO.
REQ-010 SHALL have port fifo_read_ack  input  1  FIFO pop acknowledge, valid one cycle after the request.
REQ-011 SHALL have port fifo_data  input  DATA_WIDTH  popped character, valid with fifo_read_ack.
REQ-012 SHALL have port tx  output  1  registered serial line, idle high.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement the states IDLE, FETCH, START, DATA and STOP.
REQ-016 IDLE with enable=1 and fifo_empty=0 SHALL assert fifo_read_enable for exactly one cycle and enter FETCH.
REQ-017 FETCH SHALL last exactly one cycle: with fifo_read_ack=1 it latches fifo_data into the shift register and enters START; otherwise it returns to IDLE without a frame (flush race).
REQ-018 fifo_read_enable SHALL never be asserted outside the IDLE-to-FETCH transition; at most one pop is outstanding.
REQ-019 tx SHALL go low in the cycle START is entered, i.e. two cycles after fifo_read_enable rises.
REQ-020 baud_div SHALL be sampled on entry to START and held constant for the whole frame.
REQ-021 START SHALL drive tx=0 for D+1 cycles, where D is the sampled divisor.
REQ-022 DATA SHALL drive DATA_WIDTH bits LSB first, each for D+1 cycles.
REQ-023 STOP SHALL drive tx=1 for STOP_BITS*(D+1) cycles.
REQ-024 The baud counter SHALL count down from D to 0 and reload on 0; the bit counter SHALL be clog2(DATA_WIDTH+1) bits wide; neither counter may wrap within a bit or frame.
REQ-025 D=0 SHALL be legal and give one cycle per bit.
REQ-026 tx_done SHALL pulse in the first IDLE cycle after STOP; a new pop may issue in that same cycle, giving a 2-cycle idle-high gap between back-to-back frames.
REQ-027 Deasserting enable mid-frame SHALL complete the current frame and then block further pops.
REQ-028 fifo_empty going high mid-frame SHALL NOT affect the frame in flight.
REQ-029 Changes to baud_div mid-frame SHALL take effect only at the next START.

Reset
REQ-030 resetn=1 SHALL force IDLE, tx=1, busy=0, tx_done=0, fifo_read_enable=0 and clear both counters and the shift register on the next clk edge.
REQ-031 Reset mid-frame SHALL abort the frame; tx returns high in the cycle after reset is sampled, and the popped character is discarded.
REQ-032 A fifo_read_ack arriving in the first cycle after reset SHALL be ignored.

Structure
REQ-033 State encoding and the IDLE-level constant for tx SHALL live in the shared UART package used by the UART blocks.
REQ-034 The baud-tick divider SHALL be a sub-module, uart_baud_tick (load, divisor, tick output), reusable by the RX path; everything else stays flat.

Verification
REQ-035 Single byte: D=3, FIFO holds 0xA5, enable=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulses at cycle 42 after fifo_read_enable; busy high for exactly 41 cycles.
REQ-036 Back-to-back: D=0, FIFO holds 0x00 then 0xFF -> two 10-cycle frames separated by exactly 2 idle-high cycles; exactly 2 pops; FIFO empty at the end.
REQ-037 Flush race: FIFO flushed in the FETCH cycle so no ack arrives -> no start bit, tx stays 1, state returns to IDLE, no tx_done.
REQ-038 Enable drop: enable cleared midway through the DATA bits of 0x3C with 2 bytes queued -> the 0x3C frame completes and no further fifo_read_enable is asserted until enable returns to 1.
REQ-039 Reset mid-frame: resetn pulsed during bit 4 -> tx=1 and busy=0 the next cycle; the next frame starts cleanly with the following FIFO entry.
REQ-040 Divisor change: baud_div changed from 1 to 7 mid-frame -> the current frame keeps 2-cycle bits and the next frame uses 8-cycle bits; with STOP_BITS=2 the stop period is 16 cycles.
